// File: rtl/stoch_signed_decode_mat.sv
// Signed stochastic bitstream decoder for a NUM_ROWS x NUM_COLS matrix: accumulates (Y_p - Y_m) over 2^WINDOW_BITS cycles.
// Optional build macro STOCH_DECODE_CONTINUOUS_EN keeps decoding back-to-back windows until abort.
module stoch_signed_decode_mat #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_BITS = 8,
    localparam int NUM_EL     = NUM_ROWS * NUM_COLS,
    localparam int OUT_W      = WINDOW_BITS + 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_EL-1:0]         Y_p,
    input  logic [NUM_EL-1:0]         Y_m,
    output logic                      busy,
    output logic                      valid,
    output logic [NUM_EL*OUT_W-1:0]   Y_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [WINDOW_BITS-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]          acc_q [NUM_EL];
    logic [OUT_W-1:0]          acc_d [NUM_EL];
    logic [NUM_EL*OUT_W-1:0]   y_out_q, y_out_d;
    logic                      valid_q, valid_d;
    logic                      last_s;

    // p=m=1 cancels, so only the exclusive cases contribute
    function automatic logic [OUT_W-1:0] delta_f(input logic p, input logic m);
        case ({p, m})
            2'b10:   return {{(OUT_W-1){1'b0}}, 1'b1};
            2'b01:   return {OUT_W{1'b1}};
            default: return {OUT_W{1'b0}};
        endcase
    endfunction

    assign last_s = (cnt_q == {WINDOW_BITS{1'b1}});
    assign busy   = (state_q == RUN);
    assign valid  = valid_q;
    assign Y_out  = y_out_q;

    // State register and datapath flops
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= {WINDOW_BITS{1'b0}};
            y_out_q <= {(NUM_EL*OUT_W){1'b0}};
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_EL; k++) begin
                acc_q[k] <= {OUT_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_out_q <= y_out_d;
            valid_q <= valid_d;
            for (int k = 0; k < NUM_EL; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Next-state logic; abort outranks window completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_s) begin
`ifdef STOCH_DECODE_CONTINUOUS_EN
                    state_d = RUN;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, accumulators and result capture
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        y_out_d = y_out_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = {WINDOW_BITS{1'b0}};
                    for (int k = 0; k < NUM_EL; k++) begin
                        acc_d[k] = {OUT_W{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                if (abort) begin
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + WINDOW_BITS'(1);
                    for (int k = 0; k < NUM_EL; k++) begin
                        acc_d[k] = acc_q[k] + delta_f(Y_p[k], Y_m[k]);
                    end
                    if (last_s) begin
                        // Final sample folds straight into the published sum
                        for (int k = 0; k < NUM_EL; k++) begin
                            y_out_d[k*OUT_W +: OUT_W] = acc_q[k] + delta_f(Y_p[k], Y_m[k]);
                        end
                        valid_d = 1'b1;
`ifdef STOCH_DECODE_CONTINUOUS_EN
                        cnt_d = {WINDOW_BITS{1'b0}};
                        for (int k = 0; k < NUM_EL; k++) begin
                            acc_d[k] = {OUT_W{1'b0}};
                        end
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

endmodule

// File: doc/stoch_signed_decode_mat.md
STOCH_SIGNED_DECODE_MAT -- requirements
Module: stoch_signed_decode_mat

Interface
- REQ-001: Parameter NUM_ROWS, default 2, number of matrix rows.
- REQ-002: Parameter NUM_COLS, default 2, number of matrix columns.
- REQ-003: Parameter WINDOW_BITS, default 8, decode window length of 2^WINDOW_BITS cycles; OUT_W = WINDOW_BITS+2.
- REQ-004: CLK  input  1  sole clock; all state on rising edge.
- REQ-005: nRST  input  1  reset, asynchronous, active-low.
- REQ-006: start  input  1  single-cycle request to begin a decode window.
- REQ-007: abort  input  1  cancels a window in progress.
- REQ-008: Y_p  input  NUM_ROWS*NUM_COLS  plus-polarity bitstreams, column-major, element k = j*NUM_ROWS+i.
- REQ-009: Y_m  input  NUM_ROWS*NUM_COLS  minus-polarity bitstreams, same ordering.
- REQ-010: busy  output  1  high while a window is running.
- REQ-011: valid  output  1  one-cycle pulse marking new Y_out.
- REQ-012: Y_out  output  NUM_ROWS*NUM_COLS*OUT_W  signed two's-complement sums, element k at bits [(k+1)*OUT_W-1 : k*OUT_W].

Function
- REQ-013: The FSM SHALL have two states, IDLE and RUN; busy = (state == RUN).
- REQ-014: In IDLE, start=1 SHALL clear all accumulators and the window counter and move to RUN; abort in IDLE is ignored.
- REQ-015: In RUN, each cycle each element SHALL add delta = Y_p[k] - Y_m[k] (+1, 0 or -1; p=m=1 gives 0) to its OUT_W-bit accumulator, and the counter SHALL increment.
- REQ-016: The first sample SHALL be taken in the first RUN cycle (cycle after start), and RUN SHALL last exactly 2^WINDOW_BITS cycles.
- REQ-017: On the edge ending the last RUN cycle, Y_out SHALL load accumulator+final delta for every element, and valid SHALL be 1 for exactly the following cycle.
- REQ-018: Sums SHALL lie in [-2^WINDOW_BITS, +2^WINDOW_BITS]; OUT_W prevents overflow, no saturation logic.
- REQ-019: Y_out SHALL hold its value between valid pulses.
- REQ-020: start while in RUN SHALL be ignored.
- REQ-021: abort in RUN SHALL return to IDLE on the next edge, no valid, Y_out unchanged; abort has priority over window completion in the same cycle.
- REQ-022: Latency: start sampled at cycle t -> valid at cycle t+2^WINDOW_BITS+1.

Reset
- REQ-023: nRST low SHALL asynchronously force state IDLE, counter 0, all accumulators 0, Y_out 0, valid 0, busy 0.
- REQ-024: Reset asserted mid-window SHALL discard the window; after release the block waits for start.

Configuration
- REQ-025: Macro STOCH_DECODE_CONTINUOUS_EN: when defined, at window completion without abort the FSM SHALL stay in RUN with accumulators and counter cleared, next window sampling in the immediately following cycle, valid pulsing every 2^WINDOW_BITS cycles until abort.
- REQ-026: When STOCH_DECODE_CONTINUOUS_EN is undefined, window completion SHALL return the FSM to IDLE (busy low in the valid cycle).

Verification (NUM_ROWS=2, NUM_COLS=2, WINDOW_BITS=3, OUT_W=5)
- REQ-027: start at t, Y_p[0]=1, Y_m[0]=0 constant -> valid at t+9, element 0 = +8 (5'b01000).
- REQ-028: Y_p[1]=0, Y_m[1]=1 constant; Y_p[2]=Y_m[2]=1; Y_p[3] high on 4 of 8 cycles, Y_m[3]=0 -> elements 1,2,3 = -8 (5'b11000), 0, +4.
- REQ-029: abort in 4th RUN cycle -> no valid, busy low next cycle, Y_out keeps prior values; start again -> normal result.
- REQ-030: start re-pulsed in 3rd RUN cycle -> ignored, valid still at t+9 only.
- REQ-031: nRST low in 5th RUN cycle -> Y_out=0, busy=0, valid=0 immediately; no valid until a new start.
- REQ-032: With STOCH_DECODE_CONTINUOUS_EN, single start at t -> valid at t+9, t+17, t+25, busy stays high; abort -> IDLE.
